// File: rtl/checker_pkg.sv
// Shared types and constants for the answer_checker keypad puzzle block.
package checker_pkg;

    localparam int unsigned ENTRY_W    = 10;
    localparam int unsigned MAX_DIGITS = 3;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEXT,
        S_WAIT_PROB,
        S_ENTRY,
        S_JUDGE,
        S_DISARMED
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/answer_checker_digit_accumulator.sv
// Decimal keypad entry register: value = value*10 + digit, capped at MAX_DIGITS digits.
module digit_accumulator
    import checker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               digit_strobe,
    input  logic [3:0]         digit_value,
    input  logic               clear,
    output logic [ENTRY_W-1:0] value,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] value_x10;

    assign value_x10 = (value << 3) + (value << 1);

    // Clear wins over a simultaneous digit; digits beyond the cap are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (digit_strobe && (count < 2'(MAX_DIGITS))) begin
            value <= value_x10 + ENTRY_W'(digit_value);
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/answer_checker.sv
// Checks keypad answers against the problem generator; optional idle timeout
// enabled by defining CHECKER_TIMEOUT_EN.
module answer_checker
    import checker_pkg::*;
#(
    parameter int unsigned SOLVES_REQUIRED = 3,
    parameter int unsigned MAX_WRONG       = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alarm_on,
    input  logic               prob_ready,
    input  logic [7:0]         answer,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic               gen_restart,
    output logic [ENTRY_W-1:0] entry_value,
    output logic [1:0]         digit_count,
    output logic               correct,
    output logic               wrong,
    output logic [3:0]         solved_count,
    output logic               disarmed,
    output logic               timeout
);

    if (SOLVES_REQUIRED < 1 || SOLVES_REQUIRED > 15 || MAX_WRONG < 1 || MAX_WRONG > 15 ||
        TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("answer_checker: parameter out of range");
    end

    state_t             state, state_next;
    logic [ENTRY_W-1:0] ans_q;
    logic               first_wait;
    logic [3:0]         wrong_cnt, wrong_cnt_d, solved_d;
    logic               correct_d, wrong_d, miss;
    logic               acc_clear, acc_digit, latch_ans;
    logic               timeout_hit;

    digit_accumulator u_acc (
        .clk          (clk),
        .rst          (rst),
        .digit_strobe (acc_digit),
        .digit_value  (key_code),
        .clear        (acc_clear),
        .value        (entry_value),
        .count        (digit_count)
    );

`ifdef CHECKER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (state == S_ENTRY) && !key_valid &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= alarm_on && timeout_hit;
            if (state != S_ENTRY || key_valid || timeout_hit)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign gen_restart = (state == S_NEXT);
    assign disarmed    = (state == S_DISARMED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // A wrong answer and an idle timeout share the same "miss" handling below.
    always_comb begin
        state_next  = state;
        acc_clear   = 1'b0;
        acc_digit   = 1'b0;
        latch_ans   = 1'b0;
        correct_d   = 1'b0;
        wrong_d     = 1'b0;
        miss        = 1'b0;
        solved_d    = solved_count;
        wrong_cnt_d = wrong_cnt;

        if (!alarm_on) begin
            state_next  = S_IDLE;
            acc_clear   = 1'b1;
            solved_d    = '0;
            wrong_cnt_d = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    solved_d    = '0;
                    wrong_cnt_d = '0;
                    state_next  = S_NEXT;
                end
                S_NEXT: begin
                    acc_clear  = 1'b1;
                    state_next = S_WAIT_PROB;
                end
                S_WAIT_PROB: begin
                    if (!first_wait && prob_ready) begin
                        latch_ans  = 1'b1;
                        state_next = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (key_valid) begin
                        if (is_digit(key_code))
                            acc_digit = 1'b1;
                        else if (key_code == KEY_CLEAR)
                            acc_clear = 1'b1;
                        else if (key_code == KEY_ENTER && digit_count != '0)
                            state_next = S_JUDGE;
                    end else if (timeout_hit) begin
                        miss = 1'b1;
                    end
                end
                S_JUDGE: begin
                    if (entry_value == ans_q) begin
                        correct_d   = 1'b1;
                        solved_d    = solved_count + 4'd1;
                        wrong_cnt_d = '0;
                        state_next  = (solved_d == 4'(SOLVES_REQUIRED)) ? S_DISARMED : S_NEXT;
                    end else begin
                        miss = 1'b1;
                    end
                end
                S_DISARMED: ;
                default: state_next = S_IDLE;
            endcase

            if (miss) begin
                wrong_d     = 1'b1;
                wrong_cnt_d = wrong_cnt + 4'd1;
                if (wrong_cnt_d == 4'(MAX_WRONG)) begin
                    solved_d    = '0;
                    wrong_cnt_d = '0;
                    state_next  = S_NEXT;
                end else begin
                    acc_clear  = 1'b1;
                    state_next = S_ENTRY;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ans_q        <= '0;
            first_wait   <= 1'b0;
            wrong_cnt    <= '0;
            solved_count <= '0;
            correct      <= 1'b0;
            wrong        <= 1'b0;
        end else begin
            first_wait   <= (state == S_NEXT);
            wrong_cnt    <= wrong_cnt_d;
            solved_count <= solved_d;
            correct      <= correct_d;
            wrong        <= wrong_d;
            if (latch_ans)
                ans_q <= ENTRY_W'(answer);
        end
    end

endmodule

// File: tb/tb_answer_checker.sv
// Self-checking bench for answer_checker: key-entry vector table plus judge-pulse scoreboard.
module tb_answer_checker;
    import checker_pkg::*;

    logic       clk, rst, alarm_on, prob_ready, key_valid;
    logic [7:0] answer;
    logic [3:0] key_code;
    logic       gen_restart, correct, wrong, disarmed, timeout;
    logic [9:0] entry_value;
    logic [1:0] digit_count;
    logic [3:0] solved_count;

    answer_checker #(
        .SOLVES_REQUIRED (3),
        .MAX_WRONG       (3),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alarm_on     (alarm_on),
        .prob_ready   (prob_ready),
        .answer       (answer),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .gen_restart  (gen_restart),
        .entry_value  (entry_value),
        .digit_count  (digit_count),
        .correct      (correct),
        .wrong        (wrong),
        .solved_count (solved_count),
        .disarmed     (disarmed),
        .timeout      (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    localparam logic [2:0] P_CORRECT = 3'b100;
    localparam logic [2:0] P_WRONG   = 3'b010;
    localparam logic [2:0] P_TIMEOUT = 3'b011;

    typedef struct {
        int         due;
        logic [2:0] code;
    } exp_t;

    typedef struct {
        logic [3:0] key;
        int         value;
        int         count;
    } key_vec_t;

    exp_t     sb[$];
    key_vec_t vecs[16];
    int       compared   = 0;
    int       mismatched = 0;
    int       cycle      = 0;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Advance one clock, sample after the edge, and score any judge pulse.
    task automatic tick();
        logic [2:0] code;
        exp_t       e;
        @(posedge clk);
        #1;
        cycle++;
        code = {correct, wrong, timeout};
        if (code != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'(code), 0);
            end else begin
                e = sb.pop_front();
                check("pulse_code", int'(code), int'(e.code));
                check("pulse_cycle", cycle, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            check("missing_pulse", 0, int'(e.code));
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic enter_expect(input logic [2:0] code);
        sb.push_back('{cycle + 2, code});
        press(KEY_ENTER);
        tick();
    endtask

    task automatic type_val(input int v);
        if (v >= 100) press(4'(v / 100));
        if (v >= 10)  press(4'((v / 10) % 10));
        press(4'(v % 10));
    endtask

    task automatic wait_restart();
        logic seen;
        seen = gen_restart;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = gen_restart;
        end
        check("restart_seen", int'(seen), 1);
    endtask

    // Presents a decoy answer during the cycles the checker must ignore.
    task automatic load_problem(input logic [7:0] ans);
        prob_ready = 1'b1;
        answer     = 8'd99;
        tick();
        check("restart_width", int'(gen_restart), 0);
        tick();
        answer = ans;
        tick();
        prob_ready = 1'b0;
        answer     = 8'd0;
    endtask

    initial begin
        vecs[0]  = '{4'd1,      1,   1};
        vecs[1]  = '{4'd2,      12,  2};
        vecs[2]  = '{4'd3,      123, 3};
        vecs[3]  = '{4'd4,      123, 3};
        vecs[4]  = '{4'd9,      123, 3};
        vecs[5]  = '{4'hC,      123, 3};
        vecs[6]  = '{KEY_CLEAR, 0,   0};
        vecs[7]  = '{KEY_ENTER, 0,   0};
        vecs[8]  = '{4'd0,      0,   1};
        vecs[9]  = '{4'd7,      7,   2};
        vecs[10] = '{4'hF,      7,   2};
        vecs[11] = '{KEY_CLEAR, 0,   0};
        vecs[12] = '{4'd9,      9,   1};
        vecs[13] = '{4'd9,      99,  2};
        vecs[14] = '{4'd9,      999, 3};
        vecs[15] = '{KEY_CLEAR, 0,   0};

        rst = 1'b1; alarm_on = 1'b0; prob_ready = 1'b0; answer = 8'd0;
        key_valid = 1'b0; key_code = 4'h0;
        tick();
        tick();
        check("rst_gen_restart", int'(gen_restart), 0);
        check("rst_entry", int'(entry_value), 0);
        check("rst_count", int'(digit_count), 0);
        check("rst_correct", int'(correct), 0);
        check("rst_wrong", int'(wrong), 0);
        check("rst_solved", int'(solved_count), 0);
        check("rst_disarmed", int'(disarmed), 0);
        check("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        tick();

        // Correct entry
        alarm_on = 1'b1;
        wait_restart();
        load_problem(8'd6);
        check("entry_start", int'(entry_value), 0);
        press(4'd6);
        enter_expect(P_CORRECT);
        check("solved_after_1", int'(solved_count), 1);

        // Digit cap / CLEAR / empty ENTER table
        wait_restart();
        load_problem(8'd42);
        for (int i = 0; i < 16; i++) begin
            press(vecs[i].key);
            check($sformatf("vec%0d_value", i), int'(entry_value), vecs[i].value);
            check($sformatf("vec%0d_count", i), int'(digit_count), vecs[i].count);
        end

        // Wrong limit
        for (int i = 0; i < 3; i++) begin
            type_val(41);
            enter_expect(P_WRONG);
            check($sformatf("wrong%0d_solved", i), int'(solved_count), (i < 2) ? 1 : 0);
            check($sformatf("wrong%0d_restart", i), int'(gen_restart), (i < 2) ? 0 : 1);
            if (i < 2) check($sformatf("wrong%0d_entry", i), int'(entry_value), 0);
        end

        // Disarm sequence
        wait_restart();
        load_problem(8'd6);
        type_val(6);
        enter_expect(P_CORRECT);
        wait_restart();
        load_problem(8'd200);
        type_val(200);
        enter_expect(P_CORRECT);
        check("solved_after_2", int'(solved_count), 2);
        wait_restart();
        load_problem(8'd15);
        type_val(15);
        enter_expect(P_CORRECT);
        check("disarmed_set", int'(disarmed), 1);
        check("disarmed_solved", int'(solved_count), 3);
        check("disarmed_no_restart", int'(gen_restart), 0);
        press(4'd5);
        press(KEY_ENTER);
        tick();
        check("disarmed_keys_value", int'(entry_value), 15);
        check("disarmed_keys_count", int'(digit_count), 2);
        check("disarmed_hold", int'(disarmed), 1);
        alarm_on = 1'b0;
        tick();
        check("off_disarmed", int'(disarmed), 0);
        check("off_solved", int'(solved_count), 0);
        check("off_entry", int'(entry_value), 0);
        check("off_count", int'(digit_count), 0);
        check("off_restart", int'(gen_restart), 0);

        // Abort while judging
        alarm_on = 1'b1;
        wait_restart();
        load_problem(8'd9);
        press(4'd9);
        key_valid = 1'b1;
        key_code  = KEY_ENTER;
        tick();
        key_valid = 1'b0;
        alarm_on  = 1'b0;
        tick();
        check("abort_correct", int'(correct), 0);
        check("abort_wrong", int'(wrong), 0);
        check("abort_entry", int'(entry_value), 0);
        tick();
        tick();
        check("abort_idle_restart", int'(gen_restart), 0);

        // Asynchronous reset mid-entry
        alarm_on = 1'b1;
        wait_restart();
        load_problem(8'd7);
        type_val(7);
        enter_expect(P_CORRECT);
        check("pre_rst_solved", int'(solved_count), 1);
        wait_restart();
        load_problem(8'd8);
        press(4'd1);
        check("pre_rst_entry", int'(entry_value), 1);
        #3 rst = 1'b1;
        #1;
        check("async_entry", int'(entry_value), 0);
        check("async_count", int'(digit_count), 0);
        check("async_solved", int'(solved_count), 0);
        #2 rst = 1'b0;

        // Idle timeout
        wait_restart();
        load_problem(8'd5);
`ifdef CHECKER_TIMEOUT_EN
        sb.push_back('{cycle + 16, P_TIMEOUT});
        repeat (20) tick();
        type_val(4);
        enter_expect(P_WRONG);
        check("timeout_wrong2_restart", int'(gen_restart), 0);
        type_val(4);
        enter_expect(P_WRONG);
        check("timeout_wrong3_restart", int'(gen_restart), 1);
`else
        repeat (20) tick();
        check("no_timeout", int'(timeout), 0);
        type_val(5);
        enter_expect(P_CORRECT);
        check("late_solved", int'(solved_count), 1);
`endif

        repeat (4) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
